if_prefetch_stage: RTL and testbench

//  Instruction-fetch stage with a small prefetch queue. Sits directly upstream of the IF/ID pipeline register.

---
 rtl/if_prefetch_stage_if.sv | 29 ++
 rtl/if_prefetch_stage.sv | 136 +++++++++++++
 tb/tb_if_prefetch_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_stage_if.sv
// Bus bundle for the instruction-fetch prefetch stage.
//   imem_*       : in-order read port toward instruction memory
//   redirect*    : taken-branch redirect from EX/MEM (single-cycle pulse)
//   out_*        : {instruction, PC+4} toward the IF/ID register, valid/ready
// Modports:
//   master : the fetch stage (drives requests and the IF/ID side)
//   slave  : the environment (memory, branch unit, IF/ID register)
interface if_prefetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc_next;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc_next,
    input  imem_valid, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc_next,
    output imem_valid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a small prefetch queue.
// Owns the fetch PC, issues in-order reads to instruction memory, buffers the
// returned words and presents {instruction, PC+4} to IF/ID with valid/ready.
// A branch redirect flushes the queue and discards every read still in flight.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : if_prefetch_stage_if.master (imem request/response, redirect,
//           IF/ID output handshake)
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DEPTH        = 4,
  parameter int          MAX_INFLIGHT = 2
) (
  input logic             clk,
  input logic             rst_n,
  if_prefetch_stage_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int FW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  // Architectural state
  logic [31:0]   fpc_q,      fpc_d;
  logic [PW-1:0] head_q,     head_d;
  logic [PW-1:0] tail_q,     tail_d;
  logic [CW-1:0] count_q,    count_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [IW-1:0] drop_q,     drop_d;
  logic [FW-1:0] tag_rd_q,   tag_rd_d;
  logic [FW-1:0] tag_wr_q,   tag_wr_d;

  // Storage: prefetch queue and the pc tag of each outstanding read
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] tag_pc  [MAX_INFLIGHT];

  logic issue, resp, drop_word, push, pop, credit_ok, q_nonempty;

  // The tag FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [FW-1:0] tag_inc(input logic [FW-1:0] p);
    return (32'(p) == MAX_INFLIGHT - 1) ? '0 : p + 1'b1;
  endfunction

  // Words that will still land in the queue are the live (non-dropped)
  // in-flight reads; reserving room for them means a push never overflows.
  assign credit_ok  = (32'(inflight_q) - 32'(drop_q) + 32'(count_q)) < 32'(DEPTH);
  assign issue      = rst_n && !bus.redirect &&
                      (32'(inflight_q) < 32'(MAX_INFLIGHT)) && credit_ok;
  assign resp       = bus.imem_valid;
  assign drop_word  = resp && (drop_q != '0);
  assign push       = resp && (drop_q == '0) && !bus.redirect;
  assign q_nonempty = (count_q != '0);
  assign pop        = bus.out_valid && bus.out_ready;

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fpc_q;
  assign bus.out_valid   = q_nonempty && !bus.redirect;
  assign bus.out_instr   = q_nonempty ? q_instr[head_q]      : '0;
  assign bus.out_pc_next = q_nonempty ? q_pc[head_q] + 32'd4 : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    fpc_d      = fpc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q + IW'(issue) - IW'(resp);
    drop_d     = drop_q;
    tag_rd_d   = resp  ? tag_inc(tag_rd_q) : tag_rd_q;
    tag_wr_d   = issue ? tag_inc(tag_wr_q) : tag_wr_q;

    if (bus.redirect) begin
      // Everything outstanding now is stale, except a word returning this
      // very cycle, which is already consumed (and discarded) here.
      fpc_d   = bus.redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = inflight_q - IW'(resp);
    end else begin
      if (issue)     fpc_d  = fpc_q + 32'd4;
      if (drop_word) drop_d = drop_q - 1'b1;
      if (push)      tail_d = tail_q + 1'b1;
      if (pop)       head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      fpc_q      <= fpc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by count_q and
  // the tag pointers, and the outputs are gated to 0 while the queue is empty.
  always_ff @(posedge clk) begin
    if (issue) tag_pc[tag_wr_q] <= fpc_q;
    if (push) begin
      q_instr[tail_q] <= bus.imem_rdata;
      q_pc[tail_q]    <= tag_pc[tag_rd_q];
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  a_resp_has_inflight : assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_valid |-> (inflight_q != '0)
  );

  a_push_not_full : assert property (
    @(posedge clk) disable iff (!rst_n) push |-> (32'(count_q) < DEPTH || pop)
  );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: in-order memory model with
// programmable latency plus a scoreboard of fetched PCs.
module tb_if_prefetch_stage;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          DEPTH        = 4;
  localparam int          MAX_INFLIGHT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  if_prefetch_stage_if bus_if ();

  if_prefetch_stage #(
    .RESET_PC    (RESET_PC),
    .DEPTH       (DEPTH),
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];   // outstanding reads, in request order
  logic [31:0] exp_q[$];   // pcs expected at the output, in order

  int          cyc;
  int          lat;
  logic [31:0] nxt;        // next fetch address the stage should request
  logic        ready_n;
  logic        redir_n;
  logic [31:0] redir_pc_n;
  logic        hs;
  logic [31:0] hs_pcn;
  logic        prev_stall;
  logic [31:0] prev_instr, prev_pcn;
  logic        saw_wrap;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // One clock cycle: drive inputs, let logic settle, observe and score.
  task automatic body();
    logic [31:0] pc;
    cyc++;
    hs = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus_if.imem_valid = 1'b1;
      bus_if.imem_rdata = mem_word(mem_q[0].addr);
    end else begin
      bus_if.imem_valid = 1'b0;
      bus_if.imem_rdata = '0;
    end
    bus_if.redirect    = redir_n;
    bus_if.redirect_pc = redir_pc_n;
    bus_if.out_ready   = ready_n;
    redir_n = 1'b0;
    #1;
    if (bus_if.redirect) begin
      check("redir_no_out", 32'(bus_if.out_valid), 0);
      check("redir_no_req", 32'(bus_if.imem_req), 0);
      exp_q.delete();
      nxt = bus_if.redirect_pc;
    end
    if (bus_if.imem_req) begin
      check("fetch_addr", bus_if.imem_addr, nxt);
      check("credit_inflight", 32'(mem_q.size() < MAX_INFLIGHT), 1);
      check("credit_queue", 32'(exp_q.size() < DEPTH), 1);
    end
    if (bus_if.imem_valid) void'(mem_q.pop_front());
    if (bus_if.imem_req) begin
      mem_q.push_back('{addr: bus_if.imem_addr, due: cyc + lat});
      exp_q.push_back(bus_if.imem_addr);
      nxt = nxt + 32'd4;
    end
    if (prev_stall && bus_if.out_valid) begin
      check("stall_stable_instr", bus_if.out_instr, prev_instr);
      check("stall_stable_pcn", bus_if.out_pc_next, prev_pcn);
    end
    if (bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(bus_if.out_valid), 0);
      end else begin
        pc = exp_q.pop_front();
        check("out_pc_next", bus_if.out_pc_next, pc + 32'd4);
        check("out_instr", bus_if.out_instr, mem_word(pc));
        hs     = 1'b1;
        hs_pcn = bus_if.out_pc_next;
        if (pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      end
    end
    prev_stall = bus_if.out_valid && !bus_if.out_ready;
    prev_instr = bus_if.out_instr;
    prev_pcn   = bus_if.out_pc_next;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    body();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp_pcn);
    int k = 0;
    do begin
      step();
      k++;
    end while (!hs && k < 50);
    check({tag, "_seen"}, 32'(hs), 1);
    if (hs) check(tag, hs_pcn, exp_pcn);
  endtask

  // Asynchronous reset at the current time; released after two edges.
  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.imem_valid = 1'b0;
    bus_if.imem_rdata = '0;
    bus_if.redirect   = 1'b0;
    bus_if.redirect_pc = '0;
    #1;
    check("rst_imem_req", 32'(bus_if.imem_req), 0);
    check("rst_imem_addr", bus_if.imem_addr, RESET_PC);
    check("rst_out_valid", 32'(bus_if.out_valid), 0);
    check("rst_out_instr", bus_if.out_instr, 0);
    check("rst_out_pc_next", bus_if.out_pc_next, 0);
    mem_q.delete();
    exp_q.delete();
    nxt        = RESET_PC;
    prev_stall = 1'b0;
    redir_n    = 1'b0;
    hs         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    body();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_v;
    int nv;
    cyc        = 0;
    lat        = 1;
    ready_n    = 1'b1;
    redir_n    = 1'b0;
    redir_pc_n = '0;
    saw_wrap   = 1'b0;
    prev_stall = 1'b0;
    bus_if.out_ready = 1'b1;

    // 1: reset, latency 1, always ready
    do_reset();
    first_v = 0;
    for (int i = 0; i < 10 && first_v == 0; i++) begin
      step();
      if (bus_if.out_valid) first_v = cyc;
    end
    check("t1_first_valid_cycle", first_v, 3);
    check("t1_first_pcn", hs_pcn, 32'h4);
    nv = 0;
    repeat (20) begin
      step();
      if (bus_if.out_valid) nv++;
    end
    check("t1_no_bubbles", nv, 20);

    // 2: stall 12 cycles at latency 2, then release
    lat = 2;
    ready_n = 1'b0;
    run(12);
    check("t2_req_held_low", 32'(bus_if.imem_req), 0);
    check("t2_buffered", exp_q.size(), 4);
    ready_n = 1'b1;
    run(20);

    // 3: redirect to 0x100 with two reads in flight, latency 3
    lat = 3;
    run(6);
    for (int i = 0; i < 10 && mem_q.size() != 2; i++) step();
    check("t3_two_inflight", mem_q.size(), 2);
    redir_pc_n = 32'h100;
    redir_n    = 1'b1;
    step();
    wait_out("t3_first_pcn", 32'h104);
    run(10);

    // 4: redirect coinciding with a returning word and out_ready
    lat = 2;
    run(8);
    for (int i = 0; i < 10 && !(mem_q.size() != 0 && mem_q[0].due <= cyc + 1); i++) step();
    redir_pc_n = 32'h180;
    redir_n    = 1'b1;
    step();
    check("t4_valid_in_redir", 32'(bus_if.imem_valid), 1);
    check("t4_ready_in_redir", 32'(bus_if.out_ready), 1);
    @(posedge clk);
    #1;
    check("t4_drop_cnt", 32'(dut.drop_q), mem_q.size());
    body();
    wait_out("t4_first_pcn", 32'h184);
    run(8);

    // 5: back-to-back redirects, the later one wins
    lat = 1;
    run(6);
    redir_pc_n = 32'h200;
    redir_n    = 1'b1;
    step();
    redir_pc_n = 32'h300;
    redir_n    = 1'b1;
    step();
    wait_out("t5_first_pcn", 32'h304);
    run(8);

    // 6: reset with a full queue, restart, then fpc wrap
    lat = 2;
    ready_n = 1'b0;
    run(12);
    check("t6_full_before_reset", exp_q.size(), 4);
    ready_n = 1'b1;
    lat = 1;
    do_reset();
    check("t6_restart_req", 32'(bus_if.imem_req), 1);
    check("t6_restart_addr", bus_if.imem_addr, RESET_PC);
    run(6);
    redir_pc_n = 32'hFFFF_FFF8;
    redir_n    = 1'b1;
    step();
    run(10);
    check("t6_wrap_seen", 32'(saw_wrap), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
